// File: rtl/deser8_framer.sv
// deser8_framer: serial-to-byte deserializer with a one-deep holding register.
// Bits are collected into a shift register; each completed frame is moved into
// the output holding register, or dropped with sticky overrun if the held byte
// has not been taken.
// Optional feature: define DESER_PARITY_EN for 9-bit frames (8 data + odd parity),
// which enables out_perr; otherwise frames are 8 bits and out_perr is tied low.
module deser8_framer #(
    parameter int LSB_FIRST = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sin_valid,
    input  logic       sin_bit,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_any,
    output logic       out_perr,
    output logic       overrun,
    output logic       busy
);

`ifdef DESER_PARITY_EN
    localparam int unsigned FRAME_LEN = 9;
`else
    localparam int unsigned FRAME_LEN = 8;
`endif
    localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

    logic [3:0] bit_cnt;
    logic [3:0] bit_cnt_nxt;
    logic [7:0] shreg;
    logic [7:0] shreg_nxt;
    logic       frame_done;
    logic       load;
    logic       drop;
    logic       perr_nxt;
`ifdef DESER_PARITY_EN
    logic       par_acc;
    logic       par_acc_nxt;
    logic       perr_q;
`endif

    // Next-state for the collector: shift data bits, count, detect frame end.
    always_comb begin
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        frame_done  = 1'b0;
        perr_nxt    = 1'b0;
`ifdef DESER_PARITY_EN
        par_acc_nxt = par_acc;
`endif
        if (sin_valid) begin
            frame_done  = (bit_cnt == LAST_IDX);
            bit_cnt_nxt = frame_done ? 4'd0 : bit_cnt + 4'd1;
            // Only the first 8 bits are data; the parity bit (if any) never
            // enters the shift register, so the completed byte is always shreg_nxt.
            if (bit_cnt < 4'd8) begin
                if (LSB_FIRST != 0) begin
                    shreg_nxt = {sin_bit, shreg[7:1]};
                end else begin
                    shreg_nxt = {shreg[6:0], sin_bit};
                end
            end
`ifdef DESER_PARITY_EN
            par_acc_nxt = frame_done ? 1'b0 : (par_acc ^ sin_bit);
            // Odd parity: error when the ones count over all 9 bits is even.
            perr_nxt    = ~(par_acc ^ sin_bit);
`endif
        end
        load = frame_done && (!out_valid || out_ready);
        drop = frame_done && out_valid && !out_ready;
    end

    // Collector state: bit counter, shift register (and parity accumulator).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0;
            shreg   <= '0;
`ifdef DESER_PARITY_EN
            par_acc <= 1'b0;
`endif
        end else begin
            bit_cnt <= bit_cnt_nxt;
            shreg   <= shreg_nxt;
`ifdef DESER_PARITY_EN
            par_acc <= par_acc_nxt;
`endif
        end
    end

    // Output holding register with valid/ready handshake and sticky overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_any   <= 1'b0;
            overrun   <= 1'b0;
`ifdef DESER_PARITY_EN
            perr_q    <= 1'b0;
`endif
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= shreg_nxt;
                out_any   <= |shreg_nxt;
`ifdef DESER_PARITY_EN
                perr_q    <= perr_nxt;
`endif
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end
        end
    end

`ifdef DESER_PARITY_EN
    assign out_perr = perr_q;
`else
    assign out_perr = perr_nxt;
`endif
    assign busy = (bit_cnt != 4'd0);

endmodule

// File: tb/tb_deser8_framer.sv
// Testbench for deser8_framer: two instances (LSB-first and MSB-first) share one
// input stream; a queue-based reference model predicts held bytes and a
// separate monitor compares them whenever a byte is presented.
module tb_deser8_framer;

`ifdef DESER_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sin_valid = 1'b0;
    logic       sin_bit = 1'b0;
    logic       out_ready = 1'b0;

    logic       l_valid, l_any, l_perr, l_ovr, l_busy;
    logic [7:0] l_data;
    logic       m_valid_o, m_any, m_perr, m_ovr_o, m_busy;
    logic [7:0] m_data;

    deser8_framer #(.LSB_FIRST(1)) u_lsb (
        .clk(clk), .reset(reset), .sin_valid(sin_valid), .sin_bit(sin_bit),
        .out_valid(l_valid), .out_ready(out_ready), .out_data(l_data),
        .out_any(l_any), .out_perr(l_perr), .overrun(l_ovr), .busy(l_busy)
    );

    deser8_framer #(.LSB_FIRST(0)) u_msb (
        .clk(clk), .reset(reset), .sin_valid(sin_valid), .sin_bit(sin_bit),
        .out_valid(m_valid_o), .out_ready(out_ready), .out_data(m_data),
        .out_any(m_any), .out_perr(m_perr), .overrun(m_ovr_o), .busy(m_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] lsb;
        logic [7:0] msb;
        logic       perr;
    } exp_t;

    exp_t exp_q[$];
    int   m_bits[$];
    bit   m_valid;
    bit   m_ovr;
    bit   run_mon;
    int   checks;
    int   failures;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // Reference model: applied once per clock edge with the inputs seen at that edge.
    task automatic model_update(input bit v, input bit b, input bit r);
        bit   hs;
        bit   done;
        int   ones;
        exp_t e;
        hs   = m_valid && r;
        done = 1'b0;
        e.lsb = 8'h00;
        e.msb = 8'h00;
        e.perr = 1'b0;
        if (v) begin
            m_bits.push_back(int'(b));
            if (m_bits.size() == FL) begin
                ones = 0;
                for (int i = 0; i < FL; i++) ones += m_bits[i];
                for (int i = 0; i < 8; i++) begin
                    if (m_bits[i] != 0) begin
                        e.lsb[i]     = 1'b1;
                        e.msb[7 - i] = 1'b1;
                    end
                end
`ifdef DESER_PARITY_EN
                e.perr = ((ones % 2) == 0);
`endif
                m_bits.delete();
                done = 1'b1;
            end
        end
        if (done && (!m_valid || r)) begin
            exp_q.push_back(e);
            m_valid = 1'b1;
        end else if (done) begin
            m_ovr = 1'b1;
        end else if (hs) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic step(input bit v, input bit b, input bit r);
        @(negedge clk);
        #1;
        sin_valid = v;
        sin_bit   = b;
        out_ready = r;
        @(posedge clk);
        model_update(v, b, r);
    endtask

    task automatic send_byte(input logic [7:0] d, input bit r);
        for (int i = 0; i < 8; i++) step(1'b1, d[i], r);
`ifdef DESER_PARITY_EN
        step(1'b1, ~^d, r);
`endif
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, r);
    endtask

    task automatic check_zero(input string who, input logic v, input logic [7:0] d,
                              input logic a, input logic p, input logic o, input logic bz);
        chk({who, "_rst_valid"}, {7'b0, v}, 8'h00);
        chk({who, "_rst_data"}, d, 8'h00);
        chk({who, "_rst_any"}, {7'b0, a}, 8'h00);
        chk({who, "_rst_perr"}, {7'b0, p}, 8'h00);
        chk({who, "_rst_overrun"}, {7'b0, o}, 8'h00);
        chk({who, "_rst_busy"}, {7'b0, bz}, 8'h00);
    endtask

    // Reset is raised between clock edges, so the zero check proves it is asynchronous.
    task automatic do_reset();
        @(negedge clk);
        #1;
        reset     = 1'b1;
        sin_valid = 1'b0;
        #1;
        check_zero("lsb", l_valid, l_data, l_any, l_perr, l_ovr, l_busy);
        check_zero("msb", m_valid_o, m_data, m_any, m_perr, m_ovr_o, m_busy);
        m_bits.delete();
        exp_q.delete();
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        @(negedge clk);
        #1;
        reset   = 1'b0;
        run_mon = 1'b1;
    endtask

    // Monitor: compares DUT state with the model and consumes bytes on handshake.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (run_mon && !reset) begin
                chk("lsb_valid", {7'b0, l_valid}, {7'b0, m_valid});
                chk("msb_valid", {7'b0, m_valid_o}, {7'b0, m_valid});
                chk("lsb_overrun", {7'b0, l_ovr}, {7'b0, m_ovr});
                chk("msb_overrun", {7'b0, m_ovr_o}, {7'b0, m_ovr});
                chk("lsb_busy", {7'b0, l_busy}, {7'b0, m_bits.size() != 0});
                chk("msb_busy", {7'b0, m_busy}, {7'b0, m_bits.size() != 0});
                if (m_valid && exp_q.size() != 0) begin
                    chk("lsb_data", l_data, exp_q[0].lsb);
                    chk("msb_data", m_data, exp_q[0].msb);
                    chk("lsb_any", {7'b0, l_any}, {7'b0, exp_q[0].lsb != 8'h00});
                    chk("msb_any", {7'b0, m_any}, {7'b0, exp_q[0].msb != 8'h00});
                    chk("lsb_perr", {7'b0, l_perr}, {7'b0, exp_q[0].perr});
                    chk("msb_perr", {7'b0, m_perr}, {7'b0, exp_q[0].perr});
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        run_mon  = 1'b0;
        m_valid  = 1'b0;
        m_ovr    = 1'b0;

        do_reset();

        // 1,0,1,0,... : 0x55 LSB-first, 0xAA MSB-first
        send_byte(8'h55, 1'b1);
        idle(2, 1'b1);
        // all-zero frame: out_any must stay low
        send_byte(8'h00, 1'b1);
        idle(2, 1'b1);

        // overrun: hold 0x01, second frame dropped, then drain
        send_byte(8'h01, 1'b0);
        send_byte(8'hA5, 1'b0);
        idle(2, 1'b0);
        idle(3, 1'b1);

        // second frame completes on the same edge the first is accepted
        send_byte(8'h3C, 1'b0);
        for (int i = 0; i < FL - 1; i++) step(1'b1, (i % 3) == 0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        idle(3, 1'b1);

        // reset after 3 bits, then a clean frame
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        do_reset();
        send_byte(8'h96, 1'b1);
        idle(2, 1'b1);

`ifdef DESER_PARITY_EN
        // 0x03 with correct (1) and wrong (0) odd parity
        for (int i = 0; i < 8; i++) step(1'b1, i < 2, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        idle(2, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, i < 2, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        idle(2, 1'b1);
`endif

        // randomized traffic with backpressure and one reset in the middle
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            step($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 6);
        end
        idle(4, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
